// File: rtl/apb_master_arb.sv
// Round-robin arbiter sharing one APB master port among N_REQ requesters.
// Optional build macro APB_PREADY_EN adds a pready input for slave wait states.
//
// state  | meaning
// IDLE   | bus idle, arbitrating every cycle
// SETUP  | APB setup phase (psel=1, penable=0), address/data latched
// ACCESS | APB access phase (psel=1, penable=1), completes on ready
module apb_master_arb #(
  parameter int N_REQ = 4,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req_vld,
  input  logic [N_REQ-1:0]      req_wr,
  input  logic [N_REQ*32-1:0]   req_addr,
  input  logic [N_REQ*32-1:0]   req_wdata,
  output logic [N_REQ-1:0]      req_gnt,
  output logic [N_REQ-1:0]      rsp_vld,
  output logic [31:0]           rsp_rdata,
  output logic                  psel,
  output logic                  penable,
  output logic [31:0]           paddr,
  output logic                  pwrite,
  output logic [31:0]           pwdata,
`ifdef APB_PREADY_EN
  input  logic                  pready,
`endif
  input  logic [31:0]           prdata
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t           state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] win;
  logic [IDX_W-1:0] cand;
  logic             found;
  logic             xfer_ready;
  logic             arb_now;

`ifdef APB_PREADY_EN
  assign xfer_ready = pready;
`else
  assign xfer_ready = 1'b1;
`endif

  assign arb_now = (state == IDLE) || ((state == ACCESS) && xfer_ready);

  // First requester at or after rr_ptr+1, wrapping; the previous winner is searched last.
  always_comb begin
    win   = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IDX_W'((int'(rr_ptr) + k) % N_REQ);
      if (!found && req_vld[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= IDX_W'(N_REQ - 1);
      owner     <= '0;
      req_gnt   <= '0;
      rsp_vld   <= '0;
      rsp_rdata <= '0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      paddr     <= '0;
      pwrite    <= 1'b0;
      pwdata    <= '0;
    end else begin
      req_gnt <= '0;
      rsp_vld <= '0;

      if (state == SETUP) begin
        penable <= 1'b1;
        state   <= ACCESS;
      end

      if ((state == ACCESS) && xfer_ready) begin
        rsp_vld <= N_REQ'(1) << owner;
        if (!pwrite) rsp_rdata <= prdata;
      end

      if (arb_now) begin
        if (found) begin
          state   <= SETUP;
          psel    <= 1'b1;
          penable <= 1'b0;
          owner   <= win;
          rr_ptr  <= win;
          req_gnt <= N_REQ'(1) << win;
          paddr   <= req_addr[{win, 5'd0} +: 32];
          pwrite  <= req_wr[win];
          pwdata  <= req_wdata[{win, 5'd0} +: 32];
        end else begin
          state   <= IDLE;
          psel    <= 1'b0;
          penable <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_master_arb.sv
// Directed and randomized checks of apb_master_arb against a transfer-level model
// (phase counter since grant, round-robin search over the pending set).
module tb_apb_master_arb;
  localparam int N = 4;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_vld;
  logic [N-1:0]    req_wr;
  logic [N*32-1:0] req_addr;
  logic [N*32-1:0] req_wdata;
  logic [N-1:0]    req_gnt;
  logic [N-1:0]    rsp_vld;
  logic [31:0]     rsp_rdata;
  logic            psel;
  logic            penable;
  logic [31:0]     paddr;
  logic            pwrite;
  logic [31:0]     pwdata;
  logic [31:0]     prdata;
  logic            pready_drv;

  apb_master_arb #(.N_REQ(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_vld   (req_vld),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_gnt   (req_gnt),
    .rsp_vld   (rsp_vld),
    .rsp_rdata (rsp_rdata),
    .psel      (psel),
    .penable   (penable),
    .paddr     (paddr),
    .pwrite    (pwrite),
    .pwdata    (pwdata),
`ifdef APB_PREADY_EN
    .pready    (pready_drv),
`endif
    .prdata    (prdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // model: m_t = -1 idle, 1 first bus cycle after grant, 2 access cycle(s)
  int          m_t;
  int          m_ptr;
  int          m_own;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        m_wr;
  logic [N-1:0] m_gnt, m_rsp;

  int order_q[$];
  int exp_order[5] = '{0, 1, 2, 3, 0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_t = -1; m_ptr = N - 1; m_own = 0;
    m_addr = '0; m_wdata = '0; m_rdata = '0; m_wr = 1'b0;
    m_gnt = '0; m_rsp = '0;
  endtask

  task automatic model_edge();
    int  old_t;
    bit  arb;
    bit  hit;
    int  c;
    old_t = m_t;
    arb   = 0;
    m_gnt = '0;
    m_rsp = '0;
    if (old_t < 0) arb = 1;
    else if (old_t == 1) m_t = 2;
    else if (pready_drv) begin
      m_rsp[m_own] = 1'b1;
      if (!m_wr) m_rdata = prdata;
      arb = 1;
    end
    if (arb) begin
      hit = 0;
      for (int k = 1; k <= N; k++) begin
        c = (m_ptr + k) % N;
        if (!hit && req_vld[c]) begin
          hit     = 1;
          m_own   = c;
          m_ptr   = c;
          m_gnt[c] = 1'b1;
          m_addr  = req_addr[32*c +: 32];
          m_wdata = req_wdata[32*c +: 32];
          m_wr    = req_wr[c];
        end
      end
      m_t = hit ? 1 : -1;
    end
  endtask

  task automatic check_all();
    chk("psel",      {31'd0, psel},    {31'd0, m_t >= 1});
    chk("penable",   {31'd0, penable}, {31'd0, m_t == 2});
    chk("req_gnt",   {28'd0, req_gnt}, {28'd0, m_gnt});
    chk("rsp_vld",   {28'd0, rsp_vld}, {28'd0, m_rsp});
    chk("rsp_rdata", rsp_rdata, m_rdata);
    chk("paddr",     paddr,     m_addr);
    chk("pwdata",    pwdata,    m_wdata);
    chk("pwrite",    {31'd0, pwrite}, {31'd0, m_wr});
  endtask

  task automatic step();
    if (rst_n) model_edge();
    else model_reset();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic new_req(input int i);
    req_vld[i] = 1'b1;
    req_wr[i]  = 1'($urandom_range(0, 1));
    req_addr[32*i +: 32]  = $urandom();
    req_wdata[32*i +: 32] = $urandom();
  endtask

  task automatic upd_reqs();
    for (int i = 0; i < N; i++) begin
      if (m_gnt[i]) begin
        if ($urandom_range(0, 1) == 1) new_req(i);
        else req_vld[i] = 1'b0;
      end else if (!req_vld[i] && $urandom_range(0, 2) == 0) begin
        new_req(i);
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; req_vld = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
    prdata = '0; pready_drv = 1'b1;
    model_reset();
    #1;
    check_all();
    do_reset();

    // single read by requester 0
    req_vld = 4'b0001; req_wr = '0;
    req_addr[31:0] = 32'h1000_0040;
    prdata = 32'hDEAD_BEEF;
    step();
    chk("t1_gnt", {28'd0, req_gnt}, 32'h1);
    req_vld = '0;
    step();
    chk("t1_penable", {31'd0, penable}, 32'h1);
    step();
    chk("t1_rsp", {28'd0, rsp_vld}, 32'h1);
    chk("t1_rdata", rsp_rdata, 32'hDEAD_BEEF);
    step();

    // single write by requester 2; read data must not change
    req_vld = 4'b0100; req_wr = 4'b0100;
    req_addr[95:64] = 32'h0000_0010; req_wdata[95:64] = 32'h1234_5678;
    prdata = 32'h5555_AAAA;
    step();
    req_vld = '0;
    step();
    chk("t2_paddr", paddr, 32'h0000_0010);
    chk("t2_pwdata", pwdata, 32'h1234_5678);
    step();
    chk("t2_rsp", {28'd0, rsp_vld}, 32'h4);
    chk("t2_rdata", rsp_rdata, 32'hDEAD_BEEF);
    step();

    // all requesters held high from reset
    do_reset();
    req_wr = '0;
    for (int i = 0; i < N; i++) new_req(i);
    req_vld = '1;
    order_q.delete();
    for (int s = 0; s < 10; s++) begin
      step();
      for (int i = 0; i < N; i++) if (req_gnt[i]) order_q.push_back(i);
    end
    chk("t3_ngrants", order_q.size(), 5);
    for (int g = 0; g < 5 && g < order_q.size(); g++)
      chk("t3_order", order_q[g], exp_order[g]);
    req_vld = '0;
    step(); step();

    // pointer wraps past 3 to reach 1
    do_reset();
    req_vld = 4'b1000;
    step();
    req_vld = 4'b1010;
    step();
    step();
    chk("t4_gnt", {28'd0, req_gnt}, 32'h2);
    req_vld = '0;
    step(); step(); step();

    // reset during ACCESS of requester 1
    do_reset();
    req_vld = 4'b0010;
    step();
    req_vld = '0;
    step();
    chk("t5_in_access", {31'd0, penable}, 32'h1);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    req_vld = 4'b1100;
    step();
    rst_n = 1'b1;
    step();
    chk("t5_gnt", {28'd0, req_gnt}, 32'h4);
    req_vld = '0;
    step(); step(); step();

    // randomized traffic
    for (int s = 0; s < 600; s++) begin
      prdata = $urandom();
`ifdef APB_PREADY_EN
      pready_drv = ($urandom_range(0, 9) < 7);
`endif
      step();
      upd_reqs();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
